// File: rtl/btn_conditioner_pkg.sv
// rtl/btn_conditioner_pkg.sv - shared state encoding and default parameters for the button conditioner
//
// Purpose: common definitions imported by btn_debounce_ch and btn_conditioner.
//   btn_state_t    : per-channel debounce FSM state. Bit 1 equals the accepted level.
//   DEF_NB_BTN     : default number of button channels.
//   DEF_NB_COUNT   : default stability counter width.
//   DEF_N_STABLE   : default number of consecutive stable cycles needed to accept a level.
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LOW  = 2'b00,
        ST_WAIT_HIGH = 2'b01,
        ST_IDLE_HIGH = 2'b11,
        ST_WAIT_LOW  = 2'b10
    } btn_state_t;

    localparam int DEF_NB_BTN   = 4;
    localparam int DEF_NB_COUNT = 14;
    localparam int DEF_N_STABLE = 10000;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - single-channel synchronizer, debounce FSM and press/release pulse generator
//
// Purpose: conditions one raw asynchronous button line.
// Ports:
//   clock     : system clock.
//   ck_rst    : synchronous active-high reset.
//   i_btn     : raw button pin, asynchronous, 1 = pressed.
//   o_level   : debounced, registered level.
//   o_press   : one-cycle pulse on an accepted 0->1 transition.
//   o_release : one-cycle pulse on an accepted 1->0 transition.
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter int NB_COUNT = DEF_NB_COUNT,
    parameter int N_STABLE = DEF_N_STABLE
) (
    input  logic clock,
    input  logic ck_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    // Counter value at which the current cycle is the N_STABLE-th stable one.
    localparam logic [NB_COUNT-1:0] C_LAST = NB_COUNT'(N_STABLE - 1);
    // With N_STABLE of 1 the first stable sample is already enough.
    localparam bit C_ACCEPT_NOW = (N_STABLE == 1);

    logic                r_sync1;
    logic                r_sync0;
    logic [NB_COUNT-1:0] r_cnt;
    btn_state_t          r_state;
    logic                r_level;
    logic                r_press;
    logic                r_release;

    always_ff @(posedge clock) begin
        if (ck_rst) begin
            r_sync1   <= 1'b0;
            r_sync0   <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_IDLE_LOW;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync0   <= r_sync1;
            // Pulses default low so they last exactly one cycle.
            r_press   <= 1'b0;
            r_release <= 1'b0;

            case (r_state)
                ST_IDLE_LOW: begin
                    if (r_sync0) begin
                        if (C_ACCEPT_NOW) begin
                            r_state <= ST_IDLE_HIGH;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_WAIT_HIGH;
                            r_cnt   <= NB_COUNT'(1);
                        end
                    end
                end

                ST_WAIT_HIGH: begin
                    if (!r_sync0) begin
                        // Input fell back before becoming stable: discard the attempt.
                        r_state <= ST_IDLE_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_LAST) begin
                        r_state <= ST_IDLE_HIGH;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_IDLE_HIGH: begin
                    if (!r_sync0) begin
                        if (C_ACCEPT_NOW) begin
                            r_state   <= ST_IDLE_LOW;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_state <= ST_WAIT_LOW;
                            r_cnt   <= NB_COUNT'(1);
                        end
                    end
                end

                ST_WAIT_LOW: begin
                    if (r_sync0) begin
                        r_state <= ST_IDLE_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_LAST) begin
                        r_state   <= ST_IDLE_LOW;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - multi-channel push-button synchronizer and debouncer
//
// Purpose: conditions NB_BTN independent raw button lines into clean levels and
// single-cycle press/release pulses. o_btn_press is intended to drive a
// one-command-per-press consumer.
// Ports:
//   clock         : system clock.
//   ck_rst        : synchronous active-high reset.
//   i_btn         : raw button pins, asynchronous, 1 = pressed.
//   o_btn_level   : debounced, registered levels.
//   o_btn_press   : one-cycle pulse per accepted press, per channel.
//   o_btn_release : one-cycle pulse per accepted release, per channel.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int NB_BTN   = DEF_NB_BTN,
    parameter int NB_COUNT = DEF_NB_COUNT,
    parameter int N_STABLE = DEF_N_STABLE
) (
    input  logic              clock,
    input  logic              ck_rst,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_BTN-1:0] o_btn_press,
    output logic [NB_BTN-1:0] o_btn_release
);

    for (genvar gi = 0; gi < NB_BTN; gi++) begin : g_ch
        btn_debounce_ch #(
            .NB_COUNT (NB_COUNT),
            .N_STABLE (N_STABLE)
        ) u_ch (
            .clock     (clock),
            .ck_rst    (ck_rst),
            .i_btn     (i_btn[gi]),
            .o_level   (o_btn_level[gi]),
            .o_press   (o_btn_press[gi]),
            .o_release (o_btn_release[gi])
        );
    end

endmodule
